stream_splitter: RTL

STREAM_SPLITTER -- requirements
Module: stream_splitter

---
 rtl/stream_splitter_if.sv | 27 ++
 rtl/stream_splitter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/stream_splitter_if.sv
// Stream bus for stream_splitter: a dibit input stream plus the decoded
// header/sample strobes. The master side drives dibits; the slave side decodes them.
interface stream_splitter_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 8,
    parameter int NUM_CH = 2
);
    logic                       axiiv;
    logic [1:0]                 axiid;
    logic                       addr_axiov;
    logic [ADDR_W-1:0]          addr;
    logic [ADDR_W-1:0]          rec_addr;
    logic [NUM_CH-1:0]          data_axiov;
    logic [NUM_CH*DATA_W-1:0]   data;
    logic                       trunc;
    logic                       ovf;

    modport master (
        output axiiv, axiid,
        input  addr_axiov, addr, rec_addr, data_axiov, data, trunc, ovf
    );

    modport slave (
        input  axiiv, axiid,
        output addr_axiov, addr, rec_addr, data_axiov, data, trunc, ovf
    );
endinterface

// File: rtl/stream_splitter.sv
// Splits a dibit packet stream into a header address and interleaved channel samples.
// Define STREAM_SPLITTER_AUTOINC_EN to make rec_addr advance by one per record.
module stream_splitter #(
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 8,
    parameter int NUM_CH  = 2,
    parameter int MAX_REC = 4096
) (
    input  logic              clk,
    input  logic              rst,
    stream_splitter_if.slave  bus
);
    localparam int A_DIB = ADDR_W / 2;
    localparam int D_DIB = DATA_W / 2;
    localparam int AC_W  = (A_DIB > 1) ? $clog2(A_DIB) : 1;
    localparam int DC_W  = (D_DIB > 1) ? $clog2(D_DIB) : 1;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int REC_W = $clog2(MAX_REC + 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_e;

    state_e                     state_q, state_d;
    logic                       armed_q, armed_d;
    logic [AC_W-1:0]            acnt_q, acnt_d;
    logic [DC_W-1:0]            dcnt_q, dcnt_d;
    logic [CH_W-1:0]            ch_q, ch_d;
    logic [REC_W-1:0]           rec_q, rec_d;
    logic [ADDR_W-1:0]          addr_sr_q, addr_sr_d;
    logic [DATA_W-1:0]          samp_q, samp_d;
    logic [ADDR_W-1:0]          addr_q, addr_d;
    logic [ADDR_W-1:0]          rec_addr_q, rec_addr_d;
    logic [NUM_CH*DATA_W-1:0]   data_q, data_d;
    logic                       addr_v_q, addr_v_d;
    logic [NUM_CH-1:0]          data_v_q, data_v_d;
    logic                       trunc_q, trunc_d;
    logic                       ovf_q, ovf_d;

    logic [ADDR_W+1:0]          addr_cat;
    logic [DATA_W+1:0]          samp_cat;
    logic [ADDR_W-1:0]          rec_base;

    assign addr_cat = {addr_sr_q, bus.axiid};
    assign samp_cat = {samp_q, bus.axiid};

`ifdef STREAM_SPLITTER_AUTOINC_EN
    assign rec_base = addr_q + ADDR_W'(rec_q);
`else
    assign rec_base = addr_q;
`endif

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path infers a latch.
        state_d    = state_q;
        armed_d    = armed_q | ~bus.axiiv;
        acnt_d     = acnt_q;
        dcnt_d     = dcnt_q;
        ch_d       = ch_q;
        rec_d      = rec_q;
        addr_sr_d  = addr_sr_q;
        samp_d     = samp_q;
        addr_d     = addr_q;
        rec_addr_d = rec_addr_q;
        data_d     = data_q;
        addr_v_d   = 1'b0;
        data_v_d   = '0;
        trunc_d    = 1'b0;
        ovf_d      = 1'b0;

        case (state_q)
            IDLE: begin
                // armed_q blocks a packet already in flight when reset was released
                if (bus.axiiv && armed_q) begin
                    acnt_d    = AC_W'(1);
                    dcnt_d    = '0;
                    ch_d      = '0;
                    rec_d     = '0;
                    samp_d    = '0;
                    addr_sr_d = ADDR_W'(bus.axiid);
                    if (A_DIB == 1) begin
                        addr_d   = ADDR_W'(bus.axiid);
                        addr_v_d = 1'b1;
                        state_d  = DATA;
                    end else begin
                        state_d  = ADDR;
                    end
                end
            end
            ADDR: begin
                if (!bus.axiiv) begin
                    trunc_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    addr_sr_d = addr_cat[ADDR_W-1:0];
                    if (acnt_q == AC_W'(A_DIB - 1)) begin
                        addr_d   = addr_cat[ADDR_W-1:0];
                        addr_v_d = 1'b1;
                        state_d  = DATA;
                    end else begin
                        acnt_d = acnt_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (!bus.axiiv) begin
                    trunc_d = (dcnt_q != '0) || (ch_q != '0);
                    state_d = IDLE;
                end else begin
                    samp_d = samp_cat[DATA_W-1:0];
                    if (dcnt_q == DC_W'(D_DIB - 1)) begin
                        dcnt_d                        = '0;
                        data_d[ch_q*DATA_W +: DATA_W] = samp_cat[DATA_W-1:0];
                        data_v_d[ch_q]                = 1'b1;
                        rec_addr_d                    = rec_base;
                        if (ch_q == CH_W'(NUM_CH - 1)) begin
                            ch_d  = '0;
                            rec_d = rec_q + 1'b1;
                            if (rec_q == REC_W'(MAX_REC - 1)) begin
                                ovf_d   = 1'b1;
                                state_d = DRAIN;
                            end
                        end else begin
                            ch_d = ch_q + 1'b1;
                        end
                    end else begin
                        dcnt_d = dcnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (!bus.axiiv) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments and clear asynchronously on rst low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            armed_q    <= 1'b0;
            acnt_q     <= '0;
            dcnt_q     <= '0;
            ch_q       <= '0;
            rec_q      <= '0;
            addr_sr_q  <= '0;
            samp_q     <= '0;
            addr_q     <= '0;
            rec_addr_q <= '0;
            data_q     <= '0;
            addr_v_q   <= 1'b0;
            data_v_q   <= '0;
            trunc_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            armed_q    <= armed_d;
            acnt_q     <= acnt_d;
            dcnt_q     <= dcnt_d;
            ch_q       <= ch_d;
            rec_q      <= rec_d;
            addr_sr_q  <= addr_sr_d;
            samp_q     <= samp_d;
            addr_q     <= addr_d;
            rec_addr_q <= rec_addr_d;
            data_q     <= data_d;
            addr_v_q   <= addr_v_d;
            data_v_q   <= data_v_d;
            trunc_q    <= trunc_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.addr_axiov = addr_v_q;
    assign bus.addr       = addr_q;
    assign bus.rec_addr   = rec_addr_q;
    assign bus.data_axiov = data_v_q;
    assign bus.data       = data_q;
    assign bus.trunc      = trunc_q;
    assign bus.ovf        = ovf_q;
endmodule
